// File: rtl/zapper_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zapper_pkg                                                           |
// | Shared state encoding, width helper and defaults for the zapper.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package zapper_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARM      = 3'd1,
    S_BLACK    = 3'd2,
    S_TARGET   = 3'd3,
    S_COOLDOWN = 3'd4
  } state_e;

  localparam int c_N_TARGETS_DEF       = 2;
  localparam int c_COOLDOWN_FRAMES_DEF = 4;

  // Target index width; a single target still gets a 1-bit index.
  function automatic int tw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/zapper_hit_detector_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zapper_hit_detector_if                                               |
// | Gun inputs, frame strobe and flash/result outputs of the zapper.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface zapper_hit_detector_if
  import zapper_pkg::*;
#(
  parameter int N_TARGETS = c_N_TARGETS_DEF,
  parameter int TW        = tw(N_TARGETS)
);
  logic                 frame_start;
  logic                 trigger;
  logic                 detect;
  logic                 flash_active;
  logic                 flash_black;
  logic [TW-1:0]        flash_target;
  logic                 shot_done;
  logic [N_TARGETS-1:0] hit_mask;
  logic                 miss;
  logic                 cheat;
  logic                 busy;

  modport master (
    output frame_start, trigger, detect,
    input  flash_active, flash_black, flash_target, shot_done,
    input  hit_mask, miss, cheat, busy
  );

  modport slave (
    input  frame_start, trigger, detect,
    output flash_active, flash_black, flash_target, shot_done,
    output hit_mask, miss, cheat, busy
  );
endinterface
`default_nettype wire

// File: rtl/zapper_hit_detector_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | trigger_debounce                                                     |
// | Synchronizes and debounces the trigger, emits a one-cycle press.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module trigger_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic press_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   level_q;
  logic                   press_q;
  logic                   w_sample;

  assign w_sample = sync_q[SYNC_STAGES-1];
  assign press_o  = press_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], raw_i};
      press_q <= 1'b0;
      // Count only samples that disagree with the accepted level.
      if (w_sample == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == c_CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= w_sample;
        press_q <= w_sample;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/zapper_hit_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zapper_hit_detector                                                  |
// | Light-gun shot sequencer: black frame, one lit frame per target.     |
// | Option macro ZAPPER_DOUBLE_FLASH_EN: two flash frames per target.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module zapper_hit_detector
  import zapper_pkg::*;
#(
  parameter int N_TARGETS       = c_N_TARGETS_DEF,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2,
  parameter int COOLDOWN_FRAMES = c_COOLDOWN_FRAMES_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  zapper_hit_detector_if.slave zap_io
);
  localparam int TW = tw(N_TARGETS);
  localparam int CW = $clog2(COOLDOWN_FRAMES + 1);
  localparam logic [TW-1:0] c_IDX_LAST = TW'(N_TARGETS - 1);

  state_e                 state_q;
  logic [SYNC_STAGES-1:0] det_sync_q;
  logic                   sticky_q;
  logic [TW-1:0]          idx_q;
  logic [N_TARGETS-1:0]   mask_q;
  logic [N_TARGETS-1:0]   mask_d;
  logic [CW-1:0]          cd_q;
  logic                   flash_active_q, flash_black_q, shot_done_q;
  logic [TW-1:0]          flash_target_q;
  logic [N_TARGETS-1:0]   hit_mask_q;
  logic                   miss_q, cheat_q, busy_q;
  logic                   w_press, w_det, w_fs, w_hit, w_tgt_done;

  trigger_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_trig (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (zap_io.trigger),
    .press_o(w_press)
  );

  always_ff @(posedge clk) begin
    if (reset) det_sync_q <= '0;
    else       det_sync_q <= {det_sync_q[SYNC_STAGES-2:0], zap_io.detect};
  end

  assign w_det = det_sync_q[SYNC_STAGES-1];
  assign w_fs  = zap_io.frame_start;

`ifdef ZAPPER_DOUBLE_FLASH_EN
  // Frame A result is parked in first_q; frame B closes the target.
  logic phase_q, first_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      first_q <= 1'b0;
    end else if (state_q == S_TARGET && w_fs) begin
      phase_q <= ~phase_q;
      first_q <= sticky_q;
    end else if (state_q != S_TARGET) begin
      phase_q <= 1'b0;
    end
  end
  assign w_tgt_done = phase_q;
  assign w_hit      = first_q & sticky_q;
`else
  assign w_tgt_done = 1'b1;
  assign w_hit      = sticky_q;
`endif

  always_comb begin
    mask_d        = mask_q;
    mask_d[idx_q] = w_hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      sticky_q       <= 1'b0;
      idx_q          <= '0;
      mask_q         <= '0;
      cd_q           <= '0;
      flash_active_q <= 1'b0;
      flash_black_q  <= 1'b0;
      flash_target_q <= '0;
      shot_done_q    <= 1'b0;
      hit_mask_q     <= '0;
      miss_q         <= 1'b0;
      cheat_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      shot_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          sticky_q <= 1'b0;
          if (w_press) begin
            state_q <= S_ARM;
            busy_q  <= 1'b1;
          end
        end
        S_ARM: begin
          sticky_q <= 1'b0;
          if (w_fs) begin
            state_q        <= S_BLACK;
            flash_active_q <= 1'b1;
            flash_black_q  <= 1'b1;
          end
        end
        S_BLACK: begin
          if (!w_fs) begin
            sticky_q <= sticky_q | w_det;
          end else begin
            sticky_q      <= 1'b0;
            flash_black_q <= 1'b0;
            if (sticky_q) begin
              state_q        <= S_COOLDOWN;
              cd_q           <= CW'(COOLDOWN_FRAMES);
              flash_active_q <= 1'b0;
              hit_mask_q     <= '0;
              miss_q         <= 1'b0;
              cheat_q        <= 1'b1;
              shot_done_q    <= 1'b1;
            end else begin
              state_q        <= S_TARGET;
              idx_q          <= '0;
              mask_q         <= '0;
              flash_target_q <= '0;
            end
          end
        end
        S_TARGET: begin
          if (!w_fs) begin
            sticky_q <= sticky_q | w_det;
          end else begin
            sticky_q <= 1'b0;
            if (w_tgt_done) begin
              mask_q <= mask_d;
              if (idx_q == c_IDX_LAST) begin
                state_q        <= S_COOLDOWN;
                cd_q           <= CW'(COOLDOWN_FRAMES);
                flash_active_q <= 1'b0;
                flash_target_q <= '0;
                hit_mask_q     <= mask_d;
                miss_q         <= (mask_d == '0);
                cheat_q        <= 1'b0;
                shot_done_q    <= 1'b1;
              end else begin
                idx_q          <= idx_q + 1'b1;
                flash_target_q <= idx_q + 1'b1;
              end
            end
          end
        end
        S_COOLDOWN: begin
          sticky_q <= 1'b0;
          if (w_fs) begin
            cd_q <= cd_q - 1'b1;
            if (cd_q == CW'(1)) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign zap_io.flash_active = flash_active_q;
  assign zap_io.flash_black  = flash_black_q;
  assign zap_io.flash_target = flash_target_q;
  assign zap_io.shot_done    = shot_done_q;
  assign zap_io.hit_mask     = hit_mask_q;
  assign zap_io.miss         = miss_q;
  assign zap_io.cheat        = cheat_q;
  assign zap_io.busy         = busy_q;
endmodule
`default_nettype wire

// File: tb/tb_zapper_hit_detector.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_zapper_hit_detector                                               |
// | Directed vector bench: shot table plus multi-cycle corner sequences. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_zapper_hit_detector;
  import zapper_pkg::*;

  localparam int NT  = 3;
  localparam int DB  = 4;
  localparam int SS  = 2;
  localparam int CD  = 2;
  localparam int FP  = 100;
  localparam int TWL = tw(NT);
`ifdef ZAPPER_DOUBLE_FLASH_EN
  localparam int FR = 2;
`else
  localparam int FR = 1;
`endif
  localparam int BLK = 15;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  zapper_hit_detector_if #(.N_TARGETS(NT), .TW(TWL)) bus ();

  zapper_hit_detector #(
    .N_TARGETS      (NT),
    .DEBOUNCE_CYCLES(DB),
    .SYNC_STAGES    (SS),
    .COOLDOWN_FRAMES(CD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .zap_io(bus.slave)
  );

  typedef struct {
    string          name;
    logic [3:0]     tpat;   // bit0 = black frame, bit 1+i = target i
    logic [NT-1:0]  mask;
    logic           miss;
    logic           cheat;
  } vec_t;

  int checks = 0, failures = 0;
  int cyc = 0, done_cnt = 0, fcnt = 0;
  logic       det_en = 1'b0;
  logic [7:0] det_fmask = '0;
  int seq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Advance one clock; sample after the edge, then set up inputs for the next edge.
  task automatic tick();
    int ph;
    @(posedge clk);
    #1;
    cyc++;
    ph = cyc % FP;
    if (bus.shot_done) done_cnt++;
    if (ph == 50 && det_en && bus.flash_active) begin
      seq.push_back(bus.flash_black ? BLK : int'(bus.flash_target));
      fcnt++;
    end
    bus.frame_start = (ph == 0);
    bus.detect = det_en && bus.flash_active && ph >= 40 && ph <= 44 &&
                 (fcnt < 8) && det_fmask[fcnt[2:0]];
  endtask

  task automatic pull_trigger(input int n);
    bus.trigger = 1'b1;
    repeat (n) tick();
    bus.trigger = 1'b0;
  endtask

  function automatic logic [7:0] frames_of(input logic [3:0] tpat);
    logic [7:0] fm;
    fm    = '0;
    fm[0] = tpat[0];
    for (int i = 0; i < NT; i++)
      for (int r = 0; r < FR; r++) fm[1 + i*FR + r] = tpat[1 + i];
    return fm;
  endfunction

  task automatic run_shot(input string name, input logic [7:0] fmask,
                          input logic [NT-1:0] emask, input logic emiss, input logic echeat);
    int n;
    int exp_seq[$];
    seq.delete();
    fcnt = 0; done_cnt = 0; det_fmask = fmask; det_en = 1'b1;
    pull_trigger(10);
    repeat (8) tick();
    check({name, "_busy_after_press"}, int'(bus.busy), 1);
    n = 0;
    while (done_cnt == 0 && n < 1500) begin tick(); n++; end
    check({name, "_done_seen"}, done_cnt, 1);
    check({name, "_hit_mask"}, int'(bus.hit_mask), int'(emask));
    check({name, "_miss"}, int'(bus.miss), int'(emiss));
    check({name, "_cheat"}, int'(bus.cheat), int'(echeat));
    check({name, "_flash_off"}, int'(bus.flash_active), 0);
    n = 0;
    while (bus.busy && n < 400) begin tick(); n++; end
    check({name, "_idle_after_cooldown"}, int'(bus.busy), 0);
    check({name, "_single_done"}, done_cnt, 1);
    check({name, "_mask_held"}, int'(bus.hit_mask), int'(emask));
    exp_seq.push_back(BLK);
    if (!echeat)
      for (int i = 0; i < NT; i++)
        for (int r = 0; r < FR; r++) exp_seq.push_back(i);
    check({name, "_frames"}, seq.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < seq.size(); i++)
      check($sformatf("%s_frame%0d", name, i), seq[i], exp_seq[i]);
    det_en = 1'b0;
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{"none",    4'b0000, 3'b000, 1'b1, 1'b0};
    vecs[1] = '{"tgt1",    4'b0100, 3'b010, 1'b0, 1'b0};
    vecs[2] = '{"black",   4'b0001, 3'b000, 1'b0, 1'b1};
    vecs[3] = '{"tgt0_2",  4'b1010, 3'b101, 1'b0, 1'b0};
    vecs[4] = '{"all",     4'b1110, 3'b111, 1'b0, 1'b0};
    vecs[5] = '{"blk_t1",  4'b0101, 3'b000, 1'b0, 1'b1};

    reset = 1'b1;
    bus.frame_start = 1'b0;
    bus.trigger = 1'b0;
    bus.detect = 1'b0;
    repeat (3) tick();
    check("rst_outputs",
          int'({bus.flash_active, bus.flash_black, bus.flash_target, bus.shot_done,
                bus.hit_mask, bus.miss, bus.cheat}), 0);
    check("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    tick();

    // Too-short trigger pulse must not be accepted.
    pull_trigger(3);
    repeat (30) tick();
    check("short_trigger_busy", int'(bus.busy), 0);

    for (int v = 0; v < 6; v++)
      run_shot(vecs[v].name, frames_of(vecs[v].tpat), vecs[v].mask, vecs[v].miss, vecs[v].cheat);

`ifdef ZAPPER_DOUBLE_FLASH_EN
    run_shot("df_one_frame", 8'b0000_0010, 3'b000, 1'b1, 1'b0);
    run_shot("df_both",      8'b0000_0110, 3'b001, 1'b0, 1'b0);
`endif

    // Press during TARGET and during COOLDOWN are dropped; held trigger gives one press.
    seq.delete(); fcnt = 0; done_cnt = 0; det_fmask = '0; det_en = 1'b1;
    pull_trigger(10);
    n = 0;
    while (seq.size() < 2 && n < 800) begin tick(); n++; end
    check("busy_press_reached_target", seq.size(), 2);
    pull_trigger(10);
    n = 0;
    while (done_cnt == 0 && n < 1500) begin tick(); n++; end
    check("busy_press_done", done_cnt, 1);
    check("busy_press_frames", seq.size(), 1 + NT*FR);
    check("busy_press_miss", int'(bus.miss), 1);
    bus.trigger = 1'b1;
    while (cyc % FP != 50) tick();
    check("cooldown_frame0_busy", int'(bus.busy), 1);
    repeat (FP) tick();
    check("cooldown_frame1_busy", int'(bus.busy), 1);
    repeat (FP) tick();
    check("cooldown_frame2_idle", int'(bus.busy), 0);
    repeat (150) tick();
    check("held_trigger_no_rearm", int'(bus.busy), 0);
    bus.trigger = 1'b0;
    repeat (20) tick();
    det_en = 1'b0;

    // New shot, then reset while target 1 is being flashed.
    done_cnt = 0;
    pull_trigger(10);
    repeat (8) tick();
    check("rearm_busy", int'(bus.busy), 1);
    n = 0;
    while (!(bus.flash_active && !bus.flash_black && bus.flash_target == 1) && n < 800) begin
      tick(); n++;
    end
    check("reach_target1", int'(bus.flash_target), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midshot_rst_outputs",
          int'({bus.flash_active, bus.flash_black, bus.flash_target, bus.shot_done,
                bus.hit_mask, bus.miss, bus.cheat}), 0);
    check("midshot_rst_busy", int'(bus.busy), 0);
    repeat (500) tick();
    check("midshot_rst_no_done", done_cnt, 0);
    check("midshot_rst_stays_idle", int'(bus.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/zapper_hit_detector.md
Name: zapper_hit_detector

Overview:
- Light-gun shot sequencer for the Duck Hunt datapath; replaces the fixed single-target trigger/detect handling.
- Takes the raw trigger and photodiode inputs plus a frame-start pulse from the VGA timing block.
- Runs the flash sequence: one all-black frame, then one lit frame per target. The pattern generator reads the flash outputs to choose what to paint.
- Reports a per-target hit mask, a miss flag, and a cheat flag (light seen during the black frame).

Parameters:
- N_TARGETS, 2, number of targets flashed per shot (1..8).
- DEBOUNCE_CYCLES, 250000, number of consecutive stable clk cycles before the trigger level is accepted.
- SYNC_STAGES, 2, flip-flop stages on the trigger and detect synchronizers (≥2).
- COOLDOWN_FRAMES, 4, frames after a shot during which the trigger is ignored (≥1).

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse at the start of each frame, from the VGA block.
- trigger  in  1  raw gun trigger; high = pulled.
- detect  in  1  raw photodiode; high = light.
- flash_active  out  1  pattern generator shows the flash frame instead of normal video.
- flash_black  out  1  when flash_active=1: paint the whole screen black.
- flash_target  out  TW  index of the target box to paint white, all else black. TW = $clog2(max(N_TARGETS,2)).
- shot_done  out  1  one-cycle pulse when a result is published.
- hit_mask  out  N_TARGETS  bit i = target i was hit on the last shot.
- miss  out  1  last shot had no hits and was not a cheat.
- cheat  out  1  last shot was rejected because light was seen during the black frame.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs = 0.
  - Synchronizers, debounce counter, sticky flag and target index cleared.
  - Reset mid-shot aborts the shot; no shot_done is issued.
- Input conditioning:
  - trigger and detect each pass through SYNC_STAGES flops.
  - The debounced trigger level updates only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - press = one-cycle pulse on a 0→1 transition of the debounced level.
- Sticky detect flag:
  - In BLACK and TARGET, sticky <= sticky | detect_sync on every cycle.
  - On a frame_start cycle, sticky is evaluated as its registered value (the current sample is excluded), then loads 0.
- States:
  - IDLE: press → ARM. frame_start has no effect.
  - ARM: on frame_start → BLACK. flash_active=1, flash_black=1, sticky cleared.
  - BLACK: on frame_start:
    - sticky=1 → publish cheat=1, miss=0, hit_mask=0, pulse shot_done → COOLDOWN.
    - sticky=0 → TARGET with idx=0, flash_black=0.
  - TARGET: flash_target=idx. On frame_start:
    - hit_mask_next[idx] = sticky.
    - If idx = N_TARGETS-1: publish hit_mask, miss = (mask==0), cheat=0, pulse shot_done → COOLDOWN.
    - Otherwise idx = idx+1.
  - COOLDOWN: flash_active=0; counter loaded with COOLDOWN_FRAMES; decrements on each frame_start; at 0 → IDLE.
- Publishing and timing:
  - hit_mask, miss and cheat update only in the shot_done cycle and hold until the next shot_done.
  - Flash outputs change in the cycle after frame_start, so the pattern generator sees them from pixel (0,0) of the new frame onward.
  - A shot lasts 1 arm wait + 1 + N_TARGETS frames.
- Boundary conditions:
  - Presses outside IDLE are discarded, not queued.
  - A press and frame_start in the same cycle in IDLE: go to ARM; the frame_start is not consumed.
  - N_TARGETS=1: TW=1, flash_target is always 0.
  - Trigger held continuously produces a single press.

Optional Feature:
- Macro: ZAPPER_DOUBLE_FLASH_EN.
- Defined: each target is flashed for two consecutive frames; hit_mask[i] = sticky(frame A) AND sticky(frame B). A shot takes 1 + 2·N_TARGETS flash frames.
- Undefined: single frame per target, as described above.

Decomposition:
- zapper_pkg:
  - state enum (IDLE, ARM, BLACK, TARGET, COOLDOWN).
  - a tw() width function.
  - default constants for N_TARGETS and COOLDOWN_FRAMES.
- Sub-module trigger_debounce, parametrised by SYNC_STAGES and DEBOUNCE_CYCLES:
  - synchronizer, stability counter, rising-edge press pulse.
  - The detect path uses only a plain synchronizer.

Test Plan:
Bench settings: DEBOUNCE_CYCLES=4, SYNC_STAGES=2, N_TARGETS=3, COOLDOWN_FRAMES=2, frame_start every 100 cycles.
- Trigger high for 3 cycles, then low → no press, busy stays 0. Trigger high for 10 cycles → exactly one press; busy=1; ARM entered.
- Full shot, detect=0 throughout → flash_black=1 for 1 frame; flash_target sequence 0,1,2; shot_done pulse; hit_mask=000, miss=1, cheat=0.
- Detect pulsed for 5 cycles mid-frame only while flash_target=1 → hit_mask=010, miss=0.
- Detect high during the BLACK frame → shot_done at end of BLACK; cheat=1, hit_mask=000; no TARGET frames.
- Second trigger press during TARGET or COOLDOWN → ignored. New shot accepted only after 2 cooldown frame_starts.
- reset asserted during TARGET idx=1 → next cycle: all outputs 0, state IDLE, no shot_done. With ZAPPER_DOUBLE_FLASH_EN, detect in only one of target 0's two frames → hit_mask[0]=0.
